// File: rtl/polaris_uart_rx.sv
// polaris_uart_rx -- 16x oversampling UART receiver with a first-word-fall-through RX FIFO.
//
// Optional feature: define UART_RX_PARITY_EN for 8E1/8O1 frames (parity bit checked,
// sticky parity_err_o). Without it the frame is 8N1 and parity_err_o is tied low.
//
// Parameters
//   FIFO_DEPTH   RX FIFO entries, power of two, 2..256
//   SYNC_STAGES  synchroniser flops on uart_rx_i, >= 2
// Ports
//   uart_clock_i   sole clock, rising edge
//   uart_reset_i   asynchronous active-high reset
//   baud_div_i     oversample tick every baud_div_i+1 clocks (16 ticks per bit)
//   rx_en_i        receiver enable; low forces IDLE and drops any partial byte
//   parity_odd_i   1 = odd parity, 0 = even (used only with UART_RX_PARITY_EN)
//   uart_rx_i      asynchronous serial input, idle high
//   read_fifo_i    pop the FIFO head this cycle
//   read_data_o    FIFO head (8'h00 when empty)
//   rxempty_o      FIFO empty
//   rxfull_o       FIFO full
//   frame_err_o    sticky: stop bit sampled low
//   overrun_o      sticky: byte dropped because the FIFO was full
//   parity_err_o   sticky: parity mismatch
//   clear_err_i    clears all sticky error flags (a same-cycle error wins)
module polaris_uart_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        uart_clock_i,
  input  logic        uart_reset_i,
  input  logic [11:0] baud_div_i,
  input  logic        rx_en_i,
  input  logic        parity_odd_i,
  input  logic        uart_rx_i,
  input  logic        read_fifo_i,
  output logic [7:0]  read_data_o,
  output logic        rxempty_o,
  output logic        rxfull_o,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic        parity_err_o,
  input  logic        clear_err_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // ---------------------------------------------------------------------------
  // Input synchroniser and falling-edge detect on the synchronised line
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev_q;
  logic                   rx_fall;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign rx_fall = rx_prev_q & ~rx_s;

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge uart_clock_i or posedge uart_reset_i) begin
    if (uart_reset_i) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
      rx_prev_q <= rx_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [11:0] presc_q;
  logic        tick;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        push;
  logic        frame_evt;
`ifdef UART_RX_PARITY_EN
  logic        parity_evt;
`endif

  // Prescaler parks at 0 in IDLE so the first tick of a frame lands a fixed
  // distance after the detected start edge.
  assign tick = (state_q != IDLE) && (presc_q == baud_div_i);

  always_ff @(posedge uart_clock_i or posedge uart_reset_i) begin
    if (uart_reset_i) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      if (state_q == IDLE || tick) presc_q <= '0;
      else                         presc_q <= presc_q + 12'd1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    push       = 1'b0;
    frame_evt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_evt = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_idx_d  = '0;
        if (rx_en_i && rx_fall) state_d = START;
      end

      // 8th tick is mid start bit; a line back high here was a glitch.
      START: if (tick) begin
        if (tick_cnt_q == 4'd7) begin
          tick_cnt_d = '0;
          state_d    = rx_s ? IDLE : DATA;
        end else begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end
      end

      // Counter restarted at mid start bit, so each wrap is mid data bit.
      DATA: if (tick) begin
        tick_cnt_d = tick_cnt_q + 4'd1;
        if (tick_cnt_q == 4'd15) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        tick_cnt_d = tick_cnt_q + 4'd1;
        if (tick_cnt_q == 4'd15) begin
          parity_evt = rx_s != ((^shift_q) ^ parity_odd_i);
          state_d    = STOP;
        end
      end
`endif

      // Leaving at mid stop bit lets a new start edge follow immediately.
      STOP: if (tick) begin
        tick_cnt_d = tick_cnt_q + 4'd1;
        if (tick_cnt_q == 4'd15) begin
          push      = rx_s;
          frame_evt = ~rx_s;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (!rx_en_i) begin
      state_d   = IDLE;
      push      = 1'b0;
      frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_evt = 1'b0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        empty, full;
  logic        pop_ok, push_ok, overrun_evt;

  assign empty       = (wptr_q == rptr_q);
  assign full        = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_ok      = read_fifo_i && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_ok     = push && (!full || pop_ok);
  assign overrun_evt = push && full && !read_fifo_i;

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and read_data_o is forced to 0 while empty.
  always_ff @(posedge uart_clock_i) begin
    if (push_ok) mem[wptr_q[AW-1:0]] <= shift_q;
  end

  always_ff @(posedge uart_clock_i or posedge uart_reset_i) begin
    if (uart_reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PTR_ONE;
      if (pop_ok)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  assign read_data_o = empty ? 8'h00 : mem[rptr_q[AW-1:0]];
  assign rxempty_o   = empty;
  assign rxfull_o    = full;

  // ---------------------------------------------------------------------------
  // Sticky error flags: a new event outranks a same-cycle clear
  // ---------------------------------------------------------------------------
  logic frame_err_q, overrun_q;

  always_ff @(posedge uart_clock_i or posedge uart_reset_i) begin
    if (uart_reset_i) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_evt   | (frame_err_q & ~clear_err_i);
      overrun_q   <= overrun_evt | (overrun_q   & ~clear_err_i);
    end
  end

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge uart_clock_i or posedge uart_reset_i) begin
    if (uart_reset_i) parity_err_q <= 1'b0;
    else              parity_err_q <= parity_evt | (parity_err_q & ~clear_err_i);
  end

  assign parity_err_o = parity_err_q;
`else
  logic unused_parity_odd;

  assign unused_parity_odd = parity_odd_i;
  assign parity_err_o      = 1'b0;
`endif

endmodule
